timer_counter: RTL and testbench
================================

TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 SHALL have a single clock; reset SHALL be synchronous and active-high.
REQ-002 SHALL have port `clk`, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port `ADDR`, input, 32 bits: CPU data address; only ADDR[3:2] is decoded (0=CTRL, 1=PRESET, 2=COUNT, 3=unused).
REQ-005 SHALL have port `write_enable`, input, 1 bit: CPU store strobe, sampled at `clk` rising edge.
REQ-006 SHALL have port `write_data`, input, 32 bits: store data.
REQ-007 SHALL have port `read_data`, output, 32 bits: load data, combinational from ADDR.
REQ-008 SHALL have port `IRQ`, output, 1 bit: interrupt request to CPU.

Function
REQ-009 SHALL define CTRL bits as: [0] EN count enable, [2:1] MODE (0 one-shot, 1 auto-reload, 2/3 treated as 0), [3] IM interrupt mask; bits [31:4] SHALL read 0.
REQ-010 read_data SHALL be CTRL for ADDR[3:2]=0, PRESET for 1, COUNT for 2, and 32'h0 for 3.
REQ-011 A store to CTRL SHALL write bits [3:0] and SHALL clear irq_pending.
REQ-012 A store to PRESET SHALL write all 32 bits.
REQ-013 Stores to COUNT and to offset 3 SHALL be ignored.
REQ-014 FSM states SHALL be IDLE, LOAD, CNT, INT, updated on `clk` rising edge.
REQ-015 IDLE: SHALL go to LOAD if EN=1, else stay; COUNT SHALL hold.
REQ-016 LOAD: SHALL set COUNT to PRESET and go to CNT.
REQ-017 CNT: SHALL go to IDLE with COUNT held if EN=0; else if COUNT!=0 SHALL decrement COUNT and stay; else SHALL go to INT and set irq_pending.
REQ-018 INT, MODE=1: SHALL clear irq_pending and go to LOAD (IRQ is a one-cycle pulse).
REQ-019 INT, MODE!=1: SHALL clear CTRL.EN and go to IDLE; irq_pending SHALL stay set until a CTRL store.
REQ-020 IRQ SHALL equal irq_pending AND CTRL.IM, registered with no combinational path from write inputs.
REQ-021 Latency: with EN written at edge 0 and PRESET=N, irq_pending SHALL rise at edge N+3; the MODE=1 period SHALL be N+3 cycles.
REQ-022 A CTRL store in the same cycle as the INT-state EN clear SHALL take priority, so the stored EN value wins.
REQ-023 A PRESET store during CNT SHALL NOT alter COUNT and SHALL take effect at the next LOAD.
REQ-024 PRESET=0 SHALL reach INT two edges after LOAD; COUNT SHALL never wrap below 0.
REQ-025 A CTRL store clearing EN during CNT SHALL stop the count at the next edge; re-enabling SHALL pass through LOAD and reload PRESET.

Reset
REQ-026 On reset, CTRL, PRESET, COUNT and irq_pending SHALL be 0 and the state SHALL be IDLE.
REQ-027 On reset, IRQ SHALL be 0 and read_data SHALL reflect the zeroed registers.
REQ-028 Reset SHALL override any concurrent store.
REQ-029 Reset asserted mid-count SHALL abort the count with no IRQ.

Structure
REQ-030 The shared macros header SHALL hold the register offsets, CTRL bit positions, MODE codes and FSM state encodings.
REQ-031 The block SHALL be a single module with no sub-module; the address decoder/read mux stays inline.

Verification
REQ-032 PRESET=3, CTRL=4'b1001 (EN, IM, MODE0) stored at edge 0 -> IRQ=1 from edge 6, COUNT=0, EN reads 0; IRQ holds until a CTRL store, and drops the edge after that store.
REQ-033 PRESET=3, CTRL=4'b1011 (auto-reload) -> IRQ one-cycle pulses after edges 6, 12 and 18; COUNT reloads to 3 at edges 8 and 14.
REQ-034 CTRL=4'b0001 (IM=0), PRESET=2 -> FSM reaches INT and COUNT=0, but IRQ stays 0 throughout.
REQ-035 Counting from PRESET=10, store CTRL.EN=0 when COUNT=6 -> COUNT holds 5 or 6 per REQ-025 and never changes afterwards; re-enabling reloads 10.
REQ-036 One-shot run with a CTRL store of EN=1 exactly at the INT edge -> EN reads 1, FSM re-enters LOAD, and a second IRQ occurs N+3 edges later.
REQ-037 Reset at COUNT=4, then read offsets 0/4/8/12 -> all read 0 and IRQ=0; a store to COUNT of 32'hFFFF -> reads 0.

Source files
------------

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped timer/counter: register offsets,
// CTRL bit positions, MODE codes and FSM state encoding.
package timer_counter_pkg;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_UNUSED = 2'd3;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_RELOAD  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } state_t;

endpackage

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot / auto-reload modes and a
// maskable interrupt. Registers: CTRL, PRESET, COUNT at ADDR[3:2] = 0/1/2.
module timer_counter
  import timer_counter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ADDR,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        IRQ
);

  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_pending;
  state_t      state, state_next;

  logic [31:0] count_next;
  logic        pending_set, pending_clr, en_clr;
  logic        ctrl_store, preset_store;
  logic [1:0]  sel;
  logic [1:0]  mode;
  logic        unused_addr;

  assign sel          = ADDR[3:2];
  assign unused_addr  = ^{ADDR[31:4], ADDR[1:0]};
  assign mode         = ctrl[CTRL_MODE_LO +: 2];
  assign ctrl_store   = write_enable && (sel == OFF_CTRL);
  assign preset_store = write_enable && (sel == OFF_PRESET);

  always_comb begin
    state_next  = state;
    count_next  = count;
    pending_set = 1'b0;
    pending_clr = 1'b0;
    en_clr      = 1'b0;
    case (state)
      ST_IDLE: if (ctrl[CTRL_EN]) state_next = ST_LOAD;
      ST_LOAD: begin
        count_next = preset;
        state_next = ST_CNT;
      end
      ST_CNT: begin
        if (!ctrl[CTRL_EN]) begin
          state_next = ST_IDLE;
        end else if (count != '0) begin
          count_next = count - 32'd1;
        end else begin
          state_next  = ST_INT;
          pending_set = 1'b1;
        end
      end
      ST_INT: begin
        if (mode == MODE_RELOAD) begin
          pending_clr = 1'b1;
          state_next  = ST_LOAD;
        end else begin
          en_clr     = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl        <= '0;
      preset      <= '0;
      count       <= '0;
      irq_pending <= 1'b0;
      state       <= ST_IDLE;
    end else begin
      state <= state_next;
      count <= count_next;
      // A CPU store to CTRL overrides the FSM's automatic EN clear.
      if (ctrl_store)  ctrl <= write_data[3:0];
      else if (en_clr) ctrl[CTRL_EN] <= 1'b0;
      if (preset_store) preset <= write_data;
      // An expiry on the same edge as a CTRL store is not lost.
      if (pending_set)                     irq_pending <= 1'b1;
      else if (ctrl_store || pending_clr)  irq_pending <= 1'b0;
    end
  end

  // Both operands are flops, so IRQ has no path from the write inputs.
  assign IRQ = irq_pending & ctrl[CTRL_IM];

  always_comb begin
    read_data = '0;
    case (sel)
      OFF_CTRL:   read_data = {28'd0, ctrl};
      OFF_PRESET: read_data = preset;
      OFF_COUNT:  read_data = count;
      OFF_UNUSED: read_data = '0;
      default:    read_data = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Scoreboard bench for timer_counter: directed scenarios then random bus
// traffic, each cycle checked against a rule-level reference model.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ADDR;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        IRQ;

  timer_counter dut (
    .clk          (clk),
    .reset        (reset),
    .ADDR         (ADDR),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_data    (read_data),
    .IRQ          (IRQ)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic        irq;
    logic [31:0] addr;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model: timer described as an activity phase plus register values.
  typedef enum {P_IDLE, P_ARMING, P_RUNNING, P_EXPIRED} phase_t;
  phase_t      m_phase;
  bit          m_en, m_im, m_pend;
  bit   [1:0]  m_mode;
  bit   [31:0] m_preset, m_count;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    case (a[3:2])
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_edge(input bit r, input bit we, input logic [31:0] a, input logic [31:0] wd);
    bit expired_now = 0;
    if (r) begin
      m_phase = P_IDLE; m_en = 0; m_im = 0; m_mode = 0; m_pend = 0;
      m_preset = 0; m_count = 0;
      return;
    end
    if (m_phase == P_IDLE) begin
      if (m_en) m_phase = P_ARMING;
    end else if (m_phase == P_ARMING) begin
      m_count = m_preset;
      m_phase = P_RUNNING;
    end else if (m_phase == P_RUNNING) begin
      if (!m_en) m_phase = P_IDLE;
      else if (m_count > 0) m_count = m_count - 1;
      else begin m_phase = P_EXPIRED; m_pend = 1; expired_now = 1; end
    end else begin
      if (m_mode == 2'd1) begin m_pend = 0; m_phase = P_ARMING; end
      else begin m_en = 0; m_phase = P_IDLE; end
    end
    if (we && a[3:2] == 2'd0) begin
      m_en = wd[0]; m_mode = wd[2:1]; m_im = wd[3];
      if (!expired_now) m_pend = 0;
    end
    if (we && a[3:2] == 2'd1) m_preset = wd;
  endtask

  // Drive one cycle, queue the expected response, advance the model at the edge.
  task automatic step(input bit r, input bit we, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    reset = r; write_enable = we; ADDR = a; write_data = wd;
    e.rd = m_read(a); e.irq = m_pend & m_im; e.addr = a; e.cyc = cyc;
    exp_q.push_back(e);
    @(posedge clk); #1;
    cyc++;
    m_edge(r, we, a, wd);
  endtask

  task automatic idle(input int n, input logic [31:0] a);
    for (int i = 0; i < n; i++) step(0, 0, a + 32'(i % 2) * 32'd8, 32'd0);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (read_data !== e.rd) begin
        errors++;
        $display("FAIL read_data cyc=%0d addr=%h got=%h exp=%h", e.cyc, e.addr, read_data, e.rd);
      end
      checks++;
      if (IRQ !== e.irq) begin
        errors++;
        $display("FAIL irq cyc=%0d got=%b exp=%b", e.cyc, IRQ, e.irq);
      end
    end
  end

  initial begin
    logic [31:0] a, wd;
    bit r, we;
    reset = 1; write_enable = 0; ADDR = 0; write_data = 0;
    @(posedge clk); #1;
    m_edge(1, 0, 0, 0);
    // reset state, including a store concurrent with reset
    step(1, 1, 32'h0, 32'hF);
    for (int o = 0; o < 4; o++) step(0, 0, 32'(o * 4), 0);
    // one-shot with IRQ held until a CTRL store
    step(0, 1, 32'h4, 32'd3);
    step(0, 1, 32'h0, 32'h9);
    idle(12, 32'h0);
    step(0, 1, 32'h0, 32'h8);
    idle(3, 32'h0);
    // auto-reload pulses
    step(0, 1, 32'h0, 32'hB);
    idle(22, 32'h0);
    // masked interrupt, PRESET=2
    step(0, 1, 32'h4, 32'd2);
    step(0, 1, 32'h0, 32'h1);
    idle(10, 32'h0);
    // stop mid-count from PRESET=10, then re-enable
    step(0, 1, 32'h4, 32'd10);
    step(0, 1, 32'h0, 32'h9);
    idle(6, 32'h0);
    step(0, 1, 32'h0, 32'h8);
    idle(5, 32'h8);
    step(0, 1, 32'h0, 32'h9);
    idle(16, 32'h0);
    // one-shot, EN store landing on the expiry-handling edge
    step(0, 1, 32'h4, 32'd3);
    step(0, 1, 32'h0, 32'h9);
    idle(6, 32'h8);
    step(0, 1, 32'h0, 32'h9);
    idle(8, 32'h0);
    // reset mid-count, stores to COUNT/unused ignored
    step(0, 1, 32'h4, 32'd8);
    step(0, 1, 32'h0, 32'h9);
    idle(6, 32'h8);
    step(1, 0, 32'h8, 0);
    for (int o = 0; o < 4; o++) step(0, 0, 32'(o * 4), 0);
    step(0, 1, 32'h8, 32'hFFFF);
    step(0, 1, 32'hC, 32'hFFFF);
    step(0, 0, 32'h8, 0);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      we = ($urandom_range(0, 9) == 0);
      a  = $urandom;
      wd = $urandom;
      if (a[3:2] == 2'd0) wd[0] = ($urandom_range(0, 3) != 0);
      if (a[3:2] == 2'd1) wd = ($urandom_range(0, 19) == 0) ? 32'($urandom_range(0, 60)) : 32'($urandom_range(0, 7));
      step(r, we, a, wd);
    end
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
